cmlk_pulse_monitor: RTL and testbench
=====================================

CMLK_PULSE_MONITOR -- requirements
Module: cmlk_pulse_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pulse_in (min 2).
REQ-002 Parameter ACTIVE_LOW, default 0; 1 = pulse active level is low (inverted CMOS trigger line).
REQ-003 clk  input  1  single block clock (100 MHz timing-domain clock).
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  1 = monitor runs; 0 = forced to IDLE.
REQ-006 pulse_in  input  1  asynchronous pulse line under test (trigger, laser or gate pulse).
REQ-007 exp_period, exp_width  input  32 each  expected period and active width, in clk cycles.
REQ-008 tolerance  input  16  allowed absolute deviation, in cycles, for both checks.
REQ-009 timeout_cycles  input  32  maximum cycles with no active edge; 0 disables timeout.
REQ-010 clear  input  1  one-cycle pulse; clears sticky status and pulse_count.
REQ-011 meas_period, meas_width  output  32 each  last completed measurement.
REQ-012 meas_valid  output  1  one-cycle strobe; new meas_period/meas_width valid.
REQ-013 period_err, width_err  output  1 each  sticky out-of-tolerance flags.
REQ-014 timeout  output  1  sticky no-pulse flag.
REQ-015 pulse_count  output  32  completed periods since reset/clear, wraps at 2^32.

Function
REQ-016 pulse_in passes through SYNC_STAGES flops, then is normalized with ACTIVE_LOW so the internal "act" is 1 while the pulse is active.
REQ-017 Active edge = act 0->1, inactive edge = act 1->0, both detected by comparing act with its one-cycle-delayed copy.
REQ-018 States: IDLE, ARM, HIGH, LOW; reset and enable=0 both force IDLE.
REQ-019 IDLE->ARM when enable=1; ARM->HIGH on active edge (first edge only starts counters, no measurement).
REQ-020 HIGH->LOW on inactive edge, latching width_cnt into a width holding register.
REQ-021 LOW->HIGH on active edge: meas_period <= period_cnt, meas_width <= held width, meas_valid=1 on the following cycle, pulse_count +1.
REQ-022 period_cnt and width_cnt load 1 on the active-edge cycle, increment each cycle after, saturate at 0xFFFFFFFF.
REQ-023 meas_period = exact clk-cycle distance between consecutive active edges; meas_width = exact distance from active edge to inactive edge.
REQ-024 Latency: meas_valid asserts SYNC_STAGES+2 clk cycles after the pulse_in transition that completes the period.
REQ-025 Tolerance check uses 33-bit unsigned absolute difference; period_err set if |meas_period-exp_period| > tolerance, width_err likewise, evaluated in the meas_valid cycle.
REQ-026 In ARM, HIGH or LOW with timeout_cycles!=0, period_cnt reaching timeout_cycles sets timeout and returns to ARM (no meas_valid).
REQ-027 clear and a set condition in the same cycle: set wins.
REQ-028 Active edge in HIGH (missed inactive edge, pulse <1 cycle) is impossible after sync; a held-active line is caught only by the timeout.
REQ-029 enable dropped mid-measurement: abort, no meas_valid, measurement registers keep their last values.

Reset
REQ-030 rst_n=0 at a rising clk edge: state IDLE; all counters, meas_period, meas_width, pulse_count = 0; meas_valid, period_err, width_err, timeout = 0; synchronizer flops = inactive level.
REQ-031 Reset is fully synchronous; no output changes without a clk edge.

Structure
REQ-032 Package cmlk_mon_pkg holds the state encoding localparams and the counter width constant (32).
REQ-033 One sub-module, pulse_edge_sync (synchronizer, polarity normalization, rise/fall strobes), instantiated once.

Verification
REQ-034 ACTIVE_LOW=0, pulse period 1000, width 100, exp 1000/100, tol 2 -> meas_period=1000, meas_width=100 each strobe, no errors, pulse_count increments by 1 per period.
REQ-035 Same stimulus with exp_period=990, tol 5 -> period_err=1 at first meas_valid, stays set until clear, clears next cycle.
REQ-036 ACTIVE_LOW=1, low pulses of width 560 every 10000 cycles -> meas_width=560, meas_period=10000.
REQ-037 timeout_cycles=5000, pulse stops after 3 periods -> timeout=1 about 5000 cycles after last active edge, state ARM, next active edge produces no meas_valid.
REQ-038 Reset asserted mid-HIGH, then released -> all outputs zero, first edge after release gives no strobe, second gives a correct measurement.
REQ-039 Single-cycle pulse_in high pulse every 4 cycles -> meas_width=1, meas_period=4, meas_valid every 4 cycles.

Source files
------------

// File: rtl/cmlk_mon_pkg.sv
// cmlk pulse monitor shared definitions.
// State encoding, counter width and small arithmetic helpers.
package cmlk_mon_pkg;

    localparam int CNT_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } state_t;

    function automatic logic [CNT_W:0] abs_diff(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Synchronizes the raw pulse line, normalizes polarity and
// produces one-cycle rise/fall strobes of the active level.
module pulse_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic rise,
    output logic fall
);

    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    logic                   act_d;

    assign act  = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
    assign rise = act & ~act_d;
    assign fall = ~act & act_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            act_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            act_d  <= act;
        end
    end

endmodule

// File: rtl/cmlk_pulse_monitor.sv
// Measures period and active width of an asynchronous pulse line
// and flags out-of-tolerance timing and missing pulses.
module cmlk_pulse_monitor
    import cmlk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_width,
    input  logic [15:0]      tolerance,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             clear,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_valid,
    output logic             period_err,
    output logic             width_err,
    output logic             timeout,
    output logic [CNT_W-1:0] pulse_count
);

    state_t           state, state_nx;
    logic             rise, fall;
    logic [CNT_W-1:0] period_cnt, width_cnt, width_hold;
    logic             take_meas, take_d, tmo_hit;
    logic             load_cnt, hold_w, tmo_due;
    logic             p_bad, w_bad, chk;
    logic [CNT_W:0]   tol_ext;

    pulse_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign tmo_due = (timeout_cycles != '0) &&
                     (period_cnt >= timeout_cycles);

    always_comb begin
        state_nx  = state;
        take_meas = 1'b0;
        tmo_hit   = 1'b0;
        load_cnt  = 1'b0;
        hold_w    = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = ARM;
                ARM: begin
                    if (tmo_due) begin
                        tmo_hit = 1'b1;
                    end else if (rise) begin
                        load_cnt = 1'b1;
                        state_nx = HIGH;
                    end
                end
                HIGH: begin
                    if (tmo_due) begin
                        tmo_hit  = 1'b1;
                        state_nx = ARM;
                    end else if (fall) begin
                        hold_w   = 1'b1;
                        state_nx = LOW;
                    end
                end
                LOW: begin
                    if (tmo_due) begin
                        tmo_hit  = 1'b1;
                        state_nx = ARM;
                    end else if (rise) begin
                        take_meas = 1'b1;
                        load_cnt  = 1'b1;
                        state_nx  = HIGH;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Checks read the measurement registers updated one cycle earlier
    assign tol_ext = {{(CNT_W - 15){1'b0}}, tolerance};
    assign p_bad   = abs_diff(meas_period, exp_period) > tol_ext;
    assign w_bad   = abs_diff(meas_width, exp_width) > tol_ext;
    assign chk     = take_d & enable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            period_cnt  <= '0;
            width_cnt   <= '0;
            width_hold  <= '0;
            meas_period <= '0;
            meas_width  <= '0;
            take_d      <= 1'b0;
            meas_valid  <= 1'b0;
            period_err  <= 1'b0;
            width_err   <= 1'b0;
            timeout     <= 1'b0;
            pulse_count <= '0;
        end else begin
            state <= state_nx;
            if (!enable || state == IDLE || tmo_hit) begin
                period_cnt <= '0;
                width_cnt  <= '0;
            end else if (load_cnt) begin
                period_cnt <= 1;
                width_cnt  <= 1;
            end else begin
                period_cnt <= sat_inc(period_cnt);
                width_cnt  <= sat_inc(width_cnt);
            end
            if (hold_w) width_hold <= width_cnt;
            if (take_meas) begin
                meas_period <= period_cnt;
                meas_width  <= width_hold;
            end
            take_d     <= take_meas;
            meas_valid <= chk;
            period_err <= (chk & p_bad) | (period_err & ~clear);
            width_err  <= (chk & w_bad) | (width_err & ~clear);
            timeout    <= tmo_hit | (timeout & ~clear);
            if (take_meas)
                pulse_count <= clear ? 1 : pulse_count + 1'b1;
            else if (clear)
                pulse_count <= '0;
        end
    end

endmodule

// File: tb/tb_cmlk_pulse_monitor.sv
// Directed bench for cmlk_pulse_monitor: one active-high and one
// active-low instance driven with hand-timed pulse trains.
module tb_cmlk_pulse_monitor;
    import cmlk_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, enable, enable_lo, clear;
    logic        pulse_a, pulse_b;
    logic [31:0] exp_period, exp_width, timeout_cycles;
    logic [15:0] tolerance;

    logic [31:0] mp_a, mw_a, pc_a, mp_b, mw_b, pc_b;
    logic        mv_a, pe_a, we_a, to_a;
    logic        mv_b, pe_b, we_b, to_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int rise_cyc = 0;
    int strobes_a, bad_a, last_p, last_w, first_lat, last_sc;
    logic first_pe;
    int mon_p, mon_w, mon_gap;
    int strobes_b, last_p_b, last_w_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmlk_pulse_monitor #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pulse_in(pulse_a), .exp_period(exp_period),
        .exp_width(exp_width), .tolerance(tolerance),
        .timeout_cycles(timeout_cycles), .clear(clear),
        .meas_period(mp_a), .meas_width(mw_a), .meas_valid(mv_a),
        .period_err(pe_a), .width_err(we_a), .timeout(to_a),
        .pulse_count(pc_a)
    );

    cmlk_pulse_monitor #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable_lo),
        .pulse_in(pulse_b), .exp_period(exp_period),
        .exp_width(exp_width), .tolerance(tolerance),
        .timeout_cycles(timeout_cycles), .clear(clear),
        .meas_period(mp_b), .meas_width(mw_b), .meas_valid(mv_b),
        .period_err(pe_b), .width_err(we_b), .timeout(to_b),
        .pulse_count(pc_b)
    );

    always @(negedge clk) begin
        if (mv_a) begin
            if (strobes_a > 0 && mon_gap != 0 && cyc - last_sc != mon_gap)
                bad_a++;
            if (mp_a !== mon_p || mw_a !== mon_w) bad_a++;
            if (strobes_a == 0) begin
                first_pe  = pe_a;
                first_lat = cyc - rise_cyc;
            end
            last_p  = mp_a;
            last_w  = mw_a;
            last_sc = cyc;
            strobes_a++;
        end
        if (mv_b) begin
            last_p_b = mp_b;
            last_w_b = mw_b;
            strobes_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pulses(input int period, input int width,
                              input int n, input bit lo);
        for (int i = 0; i < n; i++) begin
            if (lo) pulse_b = 1'b0; else pulse_a = 1'b1;
            rise_cyc = cyc;
            repeat (width) tick();
            if (lo) pulse_b = 1'b1; else pulse_a = 1'b0;
            repeat (period - width) tick();
        end
    endtask

    task automatic restart(input int p, input int w, input int gap);
        enable = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        repeat (5) tick();
        strobes_a = 0;
        bad_a = 0;
        mon_p = p;
        mon_w = w;
        mon_gap = gap;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; enable_lo = 1'b0; clear = 1'b0;
        pulse_a = 1'b0; pulse_b = 1'b1;
        exp_period = 0; exp_width = 0; tolerance = 0; timeout_cycles = 0;
        repeat (3) tick();
        n_cmp++;
        if (mp_a !== 0) begin n_bad++; $display("FAIL rst_period: got %0d want 0", mp_a); end
        n_cmp++;
        if (mw_a !== 0) begin n_bad++; $display("FAIL rst_width: got %0d want 0", mw_a); end
        n_cmp++;
        if ({mv_a, pe_a, we_a, to_a} !== 4'b0) begin
            n_bad++; $display("FAIL rst_flags: got %b want 0000", {mv_a, pe_a, we_a, to_a});
        end
        n_cmp++;
        if (pc_a !== 0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", pc_a); end
        n_cmp++;
        if (dut.state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dut.state); end
        n_cmp++;
        if (mp_b !== 0 || mv_b !== 1'b0) begin
            n_bad++; $display("FAIL rst_lo: got %0d/%0d want 0/0", mp_b, mv_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        exp_period = 1000; exp_width = 100; tolerance = 2; timeout_cycles = 0;
        restart(1000, 100, 1000);
        run_pulses(1000, 100, 4, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (strobes_a !== 3) begin n_bad++; $display("FAIL nom_strobes: got %0d want 3", strobes_a); end
        n_cmp++;
        if (bad_a !== 0) begin n_bad++; $display("FAIL nom_values: got %0d bad strobes want 0", bad_a); end
        n_cmp++;
        if (first_lat !== 4) begin n_bad++; $display("FAIL nom_latency: got %0d want 4", first_lat); end
        n_cmp++;
        if (last_p !== 1000 || last_w !== 100) begin
            n_bad++; $display("FAIL nom_meas: got %0d/%0d want 1000/100", last_p, last_w);
        end
        n_cmp++;
        if (pe_a !== 1'b0 || we_a !== 1'b0) begin
            n_bad++; $display("FAIL nom_err: got %b%b want 00", pe_a, we_a);
        end
        n_cmp++;
        if (pc_a !== 3) begin n_bad++; $display("FAIL nom_count: got %0d want 3", pc_a); end
    endtask

    task automatic test_period_err();
        exp_period = 990; exp_width = 100; tolerance = 5;
        restart(1000, 100, 1000);
        run_pulses(1000, 100, 3, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (first_pe !== 1'b1) begin n_bad++; $display("FAIL perr_first: got %b want 1", first_pe); end
        n_cmp++;
        if (strobes_a !== 2) begin n_bad++; $display("FAIL perr_strobes: got %0d want 2", strobes_a); end
        n_cmp++;
        if (pe_a !== 1'b1 || we_a !== 1'b0) begin
            n_bad++; $display("FAIL perr_sticky: got %b%b want 10", pe_a, we_a);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (pe_a !== 1'b0) begin n_bad++; $display("FAIL perr_clear: got %b want 0", pe_a); end
        n_cmp++;
        if (pc_a !== 0) begin n_bad++; $display("FAIL cnt_clear: got %0d want 0", pc_a); end
    endtask

    task automatic test_tol_boundary();
        exp_period = 95; exp_width = 10; tolerance = 5;
        restart(100, 10, 100);
        run_pulses(100, 10, 2, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (strobes_a !== 1 || pe_a !== 1'b0 || we_a !== 1'b0) begin
            n_bad++; $display("FAIL tol_equal: got %0d/%b%b want 1/00", strobes_a, pe_a, we_a);
        end
        exp_period = 94; exp_width = 4;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (5) tick();
        run_pulses(100, 10, 2, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (pe_a !== 1'b1 || we_a !== 1'b1) begin
            n_bad++; $display("FAIL tol_over: got %b%b want 11", pe_a, we_a);
        end
    endtask

    task automatic test_active_low();
        enable_lo = 1'b1;
        repeat (5) tick();
        strobes_b = 0;
        run_pulses(10000, 560, 3, 1'b1);
        repeat (10) tick();
        n_cmp++;
        if (strobes_b !== 2) begin n_bad++; $display("FAIL lo_strobes: got %0d want 2", strobes_b); end
        n_cmp++;
        if (last_p_b !== 10000 || last_w_b !== 560) begin
            n_bad++; $display("FAIL lo_meas: got %0d/%0d want 10000/560", last_p_b, last_w_b);
        end
        enable_lo = 1'b0;
    endtask

    task automatic test_timeout();
        int waited;
        exp_period = 1000; exp_width = 100; tolerance = 2;
        timeout_cycles = 5000;
        restart(1000, 100, 1000);
        run_pulses(1000, 100, 3, 1'b0);
        waited = 0;
        while (to_a !== 1'b1 && waited < 6000) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (to_a !== 1'b1) begin
            n_bad++; $display("FAIL tmo_set: got %b want 1 within bound", to_a);
        end
        n_cmp++;
        if (cyc - rise_cyc !== 5003) begin
            n_bad++; $display("FAIL tmo_delay: got %0d want 5003", cyc - rise_cyc);
        end
        n_cmp++;
        if (dut.state !== ARM) begin n_bad++; $display("FAIL tmo_state: got %0d want 1", dut.state); end
        n_cmp++;
        if (strobes_a !== 2 || bad_a !== 0) begin
            n_bad++; $display("FAIL tmo_pre: got %0d/%0d want 2/0", strobes_a, bad_a);
        end
        run_pulses(1000, 100, 1, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (strobes_a !== 2 || to_a !== 1'b1) begin
            n_bad++; $display("FAIL tmo_after: got %0d/%b want 2/1", strobes_a, to_a);
        end
        timeout_cycles = 0;
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (5) tick();
        pulse_a = 1'b1;
        repeat (50) tick();
        n_cmp++;
        if (dut.state !== HIGH) begin n_bad++; $display("FAIL mid_high: got %0d want 2", dut.state); end
        rst_n = 1'b0;
        repeat (2) tick();
        pulse_a = 1'b0;
        n_cmp++;
        if (mp_a !== 0 || mw_a !== 0 || pc_a !== 0) begin
            n_bad++; $display("FAIL mid_regs: got %0d/%0d/%0d want 0/0/0", mp_a, mw_a, pc_a);
        end
        n_cmp++;
        if ({mv_a, pe_a, we_a, to_a} !== 4'b0) begin
            n_bad++; $display("FAIL mid_flags: got %b want 0000", {mv_a, pe_a, we_a, to_a});
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        exp_period = 200; exp_width = 20;
        strobes_a = 0; bad_a = 0;
        mon_p = 200; mon_w = 20; mon_gap = 0;
        run_pulses(200, 20, 2, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (strobes_a !== 1 || last_p !== 200 || last_w !== 20) begin
            n_bad++; $display("FAIL mid_meas: got %0d/%0d/%0d want 1/200/20", strobes_a, last_p, last_w);
        end
    endtask

    task automatic test_single_cycle();
        exp_period = 4; exp_width = 1; tolerance = 0;
        restart(4, 1, 4);
        run_pulses(4, 1, 6, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (strobes_a !== 5 || bad_a !== 0) begin
            n_bad++; $display("FAIL one_strobes: got %0d/%0d want 5/0", strobes_a, bad_a);
        end
        n_cmp++;
        if (last_p !== 4 || last_w !== 1) begin
            n_bad++; $display("FAIL one_meas: got %0d/%0d want 4/1", last_p, last_w);
        end
        n_cmp++;
        if (pe_a !== 1'b0 || we_a !== 1'b0 || pc_a !== 5) begin
            n_bad++; $display("FAIL one_status: got %b%b/%0d want 00/5", pe_a, we_a, pc_a);
        end
    endtask

    initial begin
        strobes_a = 0; bad_a = 0; last_p = 0; last_w = 0;
        first_lat = 0; last_sc = 0; first_pe = 1'b0;
        mon_p = 0; mon_w = 0; mon_gap = 0;
        strobes_b = 0; last_p_b = 0; last_w_b = 0;
        test_reset();
        test_nominal();
        test_period_err();
        test_tol_boundary();
        test_active_low();
        test_timeout();
        test_reset_mid();
        test_single_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
